// File: rtl/vga_pkg.sv
// Shared frame-buffer geometry and the write-side FSM state encoding.
package vga_pkg;

    localparam int unsigned HRES_DEFAULT = 640;
    localparam int unsigned VRES_DEFAULT = 480;
    localparam int unsigned FB_ADDR_W    = 17;
    localparam int unsigned FB_WORDS     = HRES_DEFAULT * VRES_DEFAULT / 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PEND  = 2'd1,
        S_DRAIN = 2'd2,
        S_CLEAR = 2'd3
    } state_t;

endpackage

// File: rtl/fb_addr_calc.sv
// Maps a pixel coordinate to its frame-buffer word address, byte lane and range status.
module fb_addr_calc
    import vga_pkg::*;
#(
    parameter int unsigned HRES      = HRES_DEFAULT,
    parameter int unsigned VRES      = VRES_DEFAULT,
    parameter int unsigned ADDR_W    = FB_ADDR_W,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic [9:0]        pix_x,
    input  logic [9:0]        pix_y,
    output logic [ADDR_W-1:0] word,
    output logic [1:0]        lane,
    output logic              in_range
);

    logic [18:0] lin;

    assign lin      = 19'(pix_y) * 19'(HRES) + 19'(pix_x);
    assign word     = ADDR_W'(BASE_ADDR) + ADDR_W'(lin[18:2]);
    assign lane     = lin[1:0];
    assign in_range = (32'(pix_x) < HRES) && (32'(pix_y) < VRES);

endmodule

// File: rtl/fb_writer.sv
// Frame-buffer port-A writer: coalesces pixel writes into byte-enabled words
// and performs full-screen clears.
module fb_writer
    import vga_pkg::*;
#(
    parameter int unsigned HRES      = HRES_DEFAULT,
    parameter int unsigned VRES      = VRES_DEFAULT,
    parameter int unsigned ADDR_W    = FB_ADDR_W,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [9:0]        pix_x,
    input  logic [9:0]        pix_y,
    input  logic [7:0]        pix_data,
    input  logic              clear_req,
    input  logic [7:0]        clear_value,
    output logic              busy,
    output logic              clear_done,
    output logic              oob_flag,
    output logic [ADDR_W-1:0] address_a,
    output logic [31:0]       data_a,
    output logic [3:0]        byteena_a,
    output logic              wren_a
);

    localparam int unsigned WORDS = HRES * VRES / 4;
    localparam int unsigned CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);

    state_t             state;
    state_t             state_nx;
    logic [ADDR_W-1:0]  pend_word;
    logic [31:0]        pend_data;
    logic [3:0]         pend_be;
    logic [CNT_W-1:0]   cnt;
    logic [7:0]         clr_val;
    logic               clear_last;

    logic [ADDR_W-1:0]  px_word;
    logic [1:0]         px_lane;
    logic               px_in;
    logic               take;
    logic               hit;
    logic               drop;
    logic               same;
    logic [31:0]        merged_data;
    logic [3:0]         merged_be;
    logic [31:0]        new_data;
    logic [3:0]         new_be;

    function automatic logic [31:0] put_byte(input logic [31:0] d, input logic [1:0] lane,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = d;
        r[{lane, 3'b000} +: 8] = b;
        return r;
    endfunction

    function automatic logic [3:0] lane_be(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

    fb_addr_calc #(
        .HRES      (HRES),
        .VRES      (VRES),
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE_ADDR)
    ) u_addr (
        .pix_x    (pix_x),
        .pix_y    (pix_y),
        .word     (px_word),
        .lane     (px_lane),
        .in_range (px_in)
    );

    assign take        = pix_valid && pix_ready;
    assign hit         = take && px_in;
    assign drop        = take && !px_in;
    assign same        = (px_word == pend_word);
    assign merged_data = put_byte(pend_data, px_lane, pix_data);
    assign merged_be   = pend_be | lane_be(px_lane);
    assign new_data    = put_byte(32'h0, px_lane, pix_data);
    assign new_be      = lane_be(px_lane);
    assign busy        = (state != S_IDLE);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (clear_req)
                    state_nx = hit ? S_DRAIN : S_CLEAR;
                else if (hit)
                    state_nx = S_PEND;
            end
            S_PEND: begin
                if (clear_req)
                    state_nx = (hit && !same) ? S_DRAIN : S_CLEAR;
                else if (!hit && !drop)
                    state_nx = S_IDLE;
            end
            S_DRAIN: state_nx = S_CLEAR;
            S_CLEAR: begin
                if (cnt == LAST)
                    state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            pix_ready  <= 1'b0;
            pend_word  <= '0;
            pend_data  <= '0;
            pend_be    <= '0;
            cnt        <= '0;
            clr_val    <= '0;
            clear_last <= 1'b0;
            clear_done <= 1'b0;
            oob_flag   <= 1'b0;
            address_a  <= '0;
            data_a     <= '0;
            byteena_a  <= '0;
            wren_a     <= 1'b0;
        end else begin
            state      <= state_nx;
            pix_ready  <= (state_nx == S_IDLE) || (state_nx == S_PEND);
            wren_a     <= 1'b0;
            clear_last <= 1'b0;
            clear_done <= clear_last;
            if (drop)
                oob_flag <= 1'b1;
            if ((state == S_IDLE || state == S_PEND) && clear_req) begin
                clr_val <= clear_value;
                cnt     <= '0;
            end
            case (state)
                S_IDLE: begin
                    if (hit) begin
                        pend_word <= px_word;
                        pend_data <= new_data;
                        pend_be   <= new_be;
                    end
                end
                S_PEND: begin
                    if (hit && same) begin
                        pend_data <= merged_data;
                        pend_be   <= merged_be;
                        // A clear in the same cycle flushes the merged word immediately.
                        if (clear_req) begin
                            wren_a    <= 1'b1;
                            address_a <= pend_word;
                            data_a    <= merged_data;
                            byteena_a <= merged_be;
                        end
                    end else if (hit) begin
                        wren_a    <= 1'b1;
                        address_a <= pend_word;
                        data_a    <= pend_data;
                        byteena_a <= pend_be;
                        pend_word <= px_word;
                        pend_data <= new_data;
                        pend_be   <= new_be;
                    end else if (!drop || clear_req) begin
                        wren_a    <= 1'b1;
                        address_a <= pend_word;
                        data_a    <= pend_data;
                        byteena_a <= pend_be;
                    end
                end
                S_DRAIN: begin
                    wren_a    <= 1'b1;
                    address_a <= pend_word;
                    data_a    <= pend_data;
                    byteena_a <= pend_be;
                end
                S_CLEAR: begin
                    wren_a    <= 1'b1;
                    address_a <= ADDR_W'(BASE_ADDR) + ADDR_W'(cnt);
                    data_a    <= {4{clr_val}};
                    byteena_a <= 4'hF;
                    if (cnt == LAST) begin
                        cnt        <= '0;
                        clear_last <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fb_writer.sv
// Directed bench for fb_writer: coalescing, range handling, clear and reset abort.
module tb_fb_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        pix_valid;
    logic        pix_ready;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [7:0]  pix_data;
    logic        clear_req;
    logic [7:0]  clear_value;
    logic        busy;
    logic        clear_done;
    logic        oob_flag;
    logic [16:0] address_a;
    logic [31:0] data_a;
    logic [3:0]  byteena_a;
    logic        wren_a;

    int n_assert = 0;
    int n_fail   = 0;
    int bad      = 0;

    always #5 clk = ~clk;

    fb_writer dut (
        .clk         (clk),
        .reset       (reset),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_data    (pix_data),
        .clear_req   (clear_req),
        .clear_value (clear_value),
        .busy        (busy),
        .clear_done  (clear_done),
        .oob_flag    (oob_flag),
        .address_a   (address_a),
        .data_a      (data_a),
        .byteena_a   (byteena_a),
        .wren_a      (wren_a)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int x, input int y, input logic [7:0] d);
        pix_valid = 1'b1;
        pix_x     = 10'(x);
        pix_y     = 10'(y);
        pix_data  = d;
        tick();
    endtask

    initial begin
        reset       = 1'b0;
        pix_valid   = 1'b0;
        pix_x       = '0;
        pix_y       = '0;
        pix_data    = '0;
        clear_req   = 1'b0;
        clear_value = '0;
        #12;
        check("rst_wren", wren_a, 0);
        check("rst_ready", pix_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_oob", oob_flag, 0);
        check("rst_done", clear_done, 0);
        check("rst_addr", address_a, 0);
        check("rst_data", data_a, 0);
        check("rst_be", byteena_a, 0);
        tick();
        reset = 1'b1;
        check("ready_before_edge", pix_ready, 0);
        tick();
        check("ready_after_release", pix_ready, 1);

        // single pixel (5,0)
        send(5, 0, 8'hAB);
        pix_valid = 1'b0;
        check("t1_wren_early", wren_a, 0);
        check("t1_busy", busy, 1);
        tick();
        check("t1_wren", wren_a, 1);
        check("t1_addr", address_a, 1);
        check("t1_be", byteena_a, 4'b0010);
        check("t1_lane1", data_a[15:8], 8'hAB);
        check("t1_busy_done", busy, 0);
        tick();
        check("t1_wren_off", wren_a, 0);

        // four pixels coalesce into word 162
        for (int i = 0; i < 4; i++) send(8 + i, 1, 8'(i + 1));
        pix_valid = 1'b0;
        check("t2_no_early_write", wren_a, 0);
        tick();
        check("t2_wren", wren_a, 1);
        check("t2_addr", address_a, 162);
        check("t2_be", byteena_a, 4'hF);
        check("t2_data", data_a, 32'h04030201);
        tick();

        // word crossing, then repeated lane
        send(3, 0, 8'h11);
        send(4, 0, 8'h22);
        pix_valid = 1'b0;
        check("t3a_wren", wren_a, 1);
        check("t3a_addr", address_a, 0);
        check("t3a_be", byteena_a, 4'b1000);
        check("t3a_lane3", data_a[31:24], 8'h11);
        tick();
        check("t3b_wren", wren_a, 1);
        check("t3b_addr", address_a, 1);
        check("t3b_be", byteena_a, 4'b0001);
        check("t3b_lane0", data_a[7:0], 8'h22);
        tick();
        check("t3b_wren_off", wren_a, 0);
        send(2, 0, 8'h11);
        send(2, 0, 8'h22);
        pix_valid = 1'b0;
        check("t3c_no_early_write", wren_a, 0);
        tick();
        check("t3c_wren", wren_a, 1);
        check("t3c_addr", address_a, 0);
        check("t3c_be", byteena_a, 4'b0100);
        check("t3c_lane2", data_a[23:16], 8'h22);
        tick();

        // out-of-range pixels are dropped, flag is sticky
        check("t4_oob_clear", oob_flag, 0);
        send(640, 0, 8'h77);
        pix_valid = 1'b0;
        check("t4_oob_x", oob_flag, 1);
        check("t4_busy_x", busy, 0);
        tick();
        check("t4_nowrite_x", wren_a, 0);
        send(0, 480, 8'h77);
        pix_valid = 1'b0;
        tick();
        check("t4_nowrite_y", wren_a, 0);
        check("t4_oob_sticky", oob_flag, 1);
        check("t4_busy_y", busy, 0);

        // last in-range pixel maps to the last word, lane 3
        send(639, 479, 8'h99);
        pix_valid = 1'b0;
        tick();
        check("t4_corner_wren", wren_a, 1);
        check("t4_corner_addr", address_a, 76799);
        check("t4_corner_be", byteena_a, 4'b1000);
        check("t4_corner_data", data_a[31:24], 8'h99);
        tick();

        // pixel and clear together: pixel drains first, then full clear
        pix_valid   = 1'b1;
        pix_x       = 10'd7;
        pix_y       = 10'd0;
        pix_data    = 8'h55;
        clear_req   = 1'b1;
        clear_value = 8'h3C;
        tick();
        pix_valid   = 1'b0;
        clear_req   = 1'b0;
        clear_value = 8'h00;
        check("t5_busy", busy, 1);
        check("t5_ready", pix_ready, 0);
        check("t5_wren_early", wren_a, 0);
        tick();
        check("t5_drain_wren", wren_a, 1);
        check("t5_drain_addr", address_a, 1);
        check("t5_drain_be", byteena_a, 4'b1000);
        check("t5_drain_data", data_a[31:24], 8'h55);
        check("t5_drain_ready", pix_ready, 0);
        bad = 0;
        for (int i = 0; i < 76800; i++) begin
            tick();
            if (!(wren_a === 1'b1 && address_a === 17'(i) && data_a === 32'h3C3C3C3C &&
                  byteena_a === 4'hF && clear_done === 1'b0 &&
                  (i == 76799 || pix_ready === 1'b0)))
                bad++;
            clear_req   = (i == 1000);
            clear_value = (i == 1000) ? 8'h00 : 8'h00;
        end
        clear_req = 1'b0;
        check("t5_clear_bad_words", bad, 0);
        check("t5_busy_last", busy, 0);
        tick();
        check("t5_wren_after", wren_a, 0);
        check("t5_clear_done", clear_done, 1);
        check("t5_ready_after", pix_ready, 1);
        tick();
        check("t5_clear_done_pulse", clear_done, 0);

        // reset mid-clear aborts, a new clear restarts at word 0
        clear_value = 8'h3C;
        clear_req   = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        check("t6_pre_addr", address_a, 99);
        check("t6_pre_wren", wren_a, 1);
        reset = 1'b0;
        #1;
        check("t6_rst_wren", wren_a, 0);
        check("t6_rst_ready", pix_ready, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_addr", address_a, 0);
        #2;
        reset = 1'b1;
        tick();
        check("t6_ready", pix_ready, 1);
        check("t6_oob_cleared", oob_flag, 0);
        clear_value = 8'hA5;
        clear_req   = 1'b1;
        tick();
        clear_req = 1'b0;
        check("t6_wren_early", wren_a, 0);
        check("t6_busy", busy, 1);
        tick();
        check("t6_first_wren", wren_a, 1);
        check("t6_first_addr", address_a, 0);
        check("t6_first_data", data_a, 32'hA5A5A5A5);
        tick();
        check("t6_second_addr", address_a, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
